// File: rtl/chip_emu_pkg.sv
// Shared types and constants for the quad-NAND chip emulator.
//   fault_t     - fault mode applied to one selected gate output
//   emu_state_t - coverage-session FSM states
//   GATE_A..D   - gate indices as used by Fault_Gate and the Cov layout
package chip_emu_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    SA0  = 2'b01,
    SA1  = 2'b10,
    INV  = 2'b11
  } fault_t;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    OBSERVING = 2'b01,
    COMPLETE  = 2'b10
  } emu_state_t;

  localparam logic [1:0] GATE_A = 2'd0;
  localparam logic [1:0] GATE_B = 2'd1;
  localparam logic [1:0] GATE_C = 2'd2;
  localparam logic [1:0] GATE_D = 2'd3;

  localparam int NUM_GATES = 4;
  localparam int MAX_DELAY = 3;

  // One-hot coverage nibble for one gate: bit index is {hi, lo}.
  function automatic logic [3:0] combo_onehot(input logic hi, input logic lo);
    return 4'b0001 << {hi, lo};
  endfunction

endpackage

// File: rtl/nand_gate_emu.sv
// One emulated 2-input NAND gate with configurable output latency and a
// fault stage on the output.
//   Clk, Reset - clock, synchronous active-high reset
//   a, b       - gate inputs
//   fault      - fault mode applied after the delay line
//   y          - emulated gate output
// DELAY (0..MAX_DELAY): 0 is purely combinational; N>=1 is an N-stage shift
// register of NAND results.
module nand_gate_emu
  import chip_emu_pkg::*;
#(
  parameter int DELAY = 0
) (
  input  logic   Clk,
  input  logic   Reset,
  input  logic   a,
  input  logic   b,
  input  fault_t fault,
  output logic   y
);

  logic nand_now;
  logic delayed;

  assign nand_now = ~(a & b);

  if (DELAY == 0) begin : g_comb
    assign delayed = nand_now;
  end else begin : g_shift
    logic [DELAY-1:0] stage;

    // NOTE: the delay stages are small flops, not a memory, so they are reset;
    // loading all ones makes the pins read high (NAND of idle inputs) out of reset.
    always_ff @(posedge Clk) begin
      if (Reset) begin
        stage <= '1;
      end else begin
        // NOTE: non-blocking assignments let every stage sample the old value
        // of its neighbour, which is what makes this a shift register.
        stage[0] <= nand_now;
        for (int i = 1; i < DELAY; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign delayed = stage[DELAY-1];
  end

  // Fault is applied at the pin, after the delay line.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves y
    // unassigned, which would infer a latch.
    y = delayed;
    unique case (fault)
      NONE: y = delayed;
      SA0:  y = 1'b0;
      SA1:  y = 1'b1;
      INV:  y = ~delayed;
      default: y = delayed;
    endcase
  end

endmodule

// File: rtl/chip_emulator_quad_nand.sv
// Emulates a 7400 quad 2-input NAND on the device side of the chip-checker
// pin interface, with configurable output latency, single-gate fault
// injection and input-combination coverage.
//   Clk, Reset                  - clock, synchronous active-high reset
//   Pin1/2, Pin4/5, Pin9/10,
//   Pin12/13                    - inputs of gates A, B, C, D
//   Pin3, Pin6, Pin8, Pin11     - outputs of gates A, B, C, D
//   Arm                         - start/restart a session, latch fault config
//   Stop                        - end a session (from Complete: back to Idle)
//   Fault_Sel, Fault_Gate       - fault mode and target gate, taken on Arm
//   Cov                         - coverage, bit gate*4+{hi,lo}
//   Cov_Full                    - all coverage bits set
//   Done                        - session complete
module chip_emulator_quad_nand
  import chip_emu_pkg::*;
#(
  parameter int DELAY = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Pin1,
  input  logic        Pin2,
  output logic        Pin3,
  input  logic        Pin4,
  input  logic        Pin5,
  output logic        Pin6,
  output logic        Pin8,
  input  logic        Pin9,
  input  logic        Pin10,
  output logic        Pin11,
  input  logic        Pin12,
  input  logic        Pin13,
  input  logic        Arm,
  input  logic        Stop,
  input  logic [1:0]  Fault_Sel,
  input  logic [1:0]  Fault_Gate,
  output logic [15:0] Cov,
  output logic        Cov_Full,
  output logic        Done
);

  emu_state_t  state_q, state_d;
  logic [15:0] cov_q, cov_d;
  logic [15:0] hits;
  logic        done_q;
  fault_t      fault_q;
  logic [1:0]  fault_gate_q;

  // Index order is gate A..D; lo is the lower-numbered pin of each pair.
  logic [NUM_GATES-1:0] in_lo, in_hi, gate_y;
  fault_t               gate_fault [NUM_GATES];

  assign in_lo = {Pin12, Pin9,  Pin4, Pin1};
  assign in_hi = {Pin13, Pin10, Pin5, Pin2};
  assign {Pin11, Pin8, Pin6, Pin3} = gate_y;

  // Only the latched target gate sees the latched fault.
  always_comb begin
    for (int g = 0; g < NUM_GATES; g++) begin
      gate_fault[g] = (fault_gate_q == 2'(g)) ? fault_q : NONE;
    end
  end

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    nand_gate_emu #(.DELAY(DELAY)) u_gate (
      .Clk   (Clk),
      .Reset (Reset),
      .a     (in_lo[g]),
      .b     (in_hi[g]),
      .fault (gate_fault[g]),
      .y     (gate_y[g])
    );
  end

  always_comb begin
    hits = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      hits[g*4 +: 4] = combo_onehot(in_hi[g], in_lo[g]);
    end
  end

  // Arm is honoured in every state and takes priority over Stop and over
  // coverage completing on the same edge.
  always_comb begin
    state_d = state_q;
    cov_d   = cov_q;
    unique case (state_q)
      IDLE: begin
        if (Arm) begin
          state_d = OBSERVING;
          cov_d   = '0;
        end
      end
      OBSERVING: begin
        if (Arm) begin
          cov_d = '0;
        end else begin
          cov_d = cov_q | hits;
          if (Stop || (&cov_d)) state_d = COMPLETE;
        end
      end
      COMPLETE: begin
        if (Arm) begin
          state_d = OBSERVING;
          cov_d   = '0;
        end else if (Stop) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cov_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      cov_q        <= '0;
      done_q       <= 1'b0;
      fault_q      <= NONE;
      fault_gate_q <= GATE_A;
    end else begin
      state_q <= state_d;
      cov_q   <= cov_d;
      done_q  <= (state_d == COMPLETE);
      if (Arm) begin
        fault_q      <= fault_t'(Fault_Sel);
        fault_gate_q <= Fault_Gate;
      end
    end
  end

  assign Cov      = cov_q;
  assign Cov_Full = &cov_q;
  assign Done     = done_q;

endmodule
